// File: rtl/rr_dist_pkg.sv
// rr_dist_pkg: shared constants and types for the round-robin distributor.
package rr_dist_pkg;

   localparam int unsigned PerfCntWidth = 32;

   typedef logic [PerfCntWidth-1:0] perf_cnt_t;

endpackage

// File: rtl/rr_dist_tree_lzc.sv
// rr_dist_tree_lzc: trailing-zero counter used for the fair target search.
// empty_o flags an all-zero input; cnt_o is then 0.
module rr_dist_tree_lzc #(
   parameter int unsigned Width    = 4,
   parameter int unsigned CntWidth = $clog2(Width)
) (
   input  logic [Width-1:0]    in_i,
   output logic [CntWidth-1:0] cnt_o,
   output logic                empty_o
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      cnt_o = '0;
      for (int unsigned i = Width; i > 0; i--) begin
         if (in_i[i-1]) cnt_o = CntWidth'(i - 1);
      end
   end

   assign empty_o = ~|in_i;

endmodule

// File: rtl/rr_dist_tree.sv
// rr_dist_tree: steers one upstream req/gnt stream to NumOut downstream ports
// in rotating or externally selected order through a one-entry output register.
// Optional per-port handshake counters: define RR_DIST_PERF_CNT_EN.
module rr_dist_tree
   import rr_dist_pkg::*;
#(
   parameter int unsigned NumOut    = 4,
   parameter int unsigned DataWidth = 32,
   parameter bit          ExtSel    = 1'b0,
   parameter bit          FairDist  = 1'b1,
   parameter int unsigned IdxWidth  = $clog2(NumOut)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic [NumOut-1:0]    en_i,
   input  logic [IdxWidth-1:0]  sel_i,
   input  logic                 req_i,
   output logic                 gnt_o,
   input  logic [DataWidth-1:0] data_i,
   output logic [NumOut-1:0]    req_o,
   input  logic [NumOut-1:0]    gnt_i,
   output logic [DataWidth-1:0] data_o,
   output logic [IdxWidth-1:0]  idx_o,
   output logic                 drop_o
`ifdef RR_DIST_PERF_CNT_EN
   ,
   output perf_cnt_t [NumOut-1:0] perf_cnt_o
`endif
);

   typedef logic [IdxWidth-1:0]  idx_t;
   typedef logic [DataWidth-1:0] data_t;

   logic  valid_q;
   data_t data_q;
   idx_t  idx_q;
   idx_t  rr_q;

   idx_t  tgt_idx;
   idx_t  rr_nxt;
   logic  tgt_ok;
   logic  tgt_drop;
   logic  gnt_sel;
   logic  out_hs;
   logic  acc;

   function automatic idx_t next_idx(input idx_t i);
      return (i == idx_t'(NumOut - 1)) ? '0 : i + idx_t'(1);
   endfunction

   // Ready of the port the held beat addresses; an out-of-range index reads 0.
   always_comb begin
      gnt_sel = 1'b0;
      for (int unsigned k = 0; k < NumOut; k++) begin
         if (idx_q == idx_t'(k)) gnt_sel = gnt_i[k];
      end
   end

   assign out_hs = valid_q & gnt_sel;
   assign gnt_o  = ~rst_i & ~flush_i & (~valid_q | out_hs) & tgt_ok;
   assign acc    = req_i & gnt_o;
   assign drop_o = acc & tgt_drop;

   if (ExtSel) begin : g_ext
      logic unused_en;
      assign unused_en = ^en_i;
      assign tgt_idx   = sel_i;
      assign tgt_ok    = 1'b1;
      assign tgt_drop  = ({1'b0, sel_i} >= (IdxWidth + 1)'(NumOut));
      assign rr_nxt    = '0;
   end else begin : g_rr
      logic unused_sel;
      assign unused_sel = ^sel_i;
      assign tgt_drop   = 1'b0;
      assign rr_nxt     = next_idx(tgt_idx);

      if (FairDist) begin : g_fair
         logic [NumOut-1:0] en_hi;
         logic [NumOut-1:0] en_lo;
         idx_t              cnt_hi;
         idx_t              cnt_lo;
         logic              empty_hi;
         logic              empty_lo;
         logic              unused_empty_lo;

         // Split enables at the pointer: search at/above it first, then wrap below.
         always_comb begin
            en_hi = '0;
            en_lo = '0;
            for (int unsigned k = 0; k < NumOut; k++) begin
               en_hi[k] = en_i[k] & (idx_t'(k) >= rr_q);
               en_lo[k] = en_i[k] & (idx_t'(k) <  rr_q);
            end
         end

         rr_dist_tree_lzc #(
            .Width    (NumOut),
            .CntWidth (IdxWidth)
         ) u_lzc_hi (
            .in_i    (en_hi),
            .cnt_o   (cnt_hi),
            .empty_o (empty_hi)
         );

         rr_dist_tree_lzc #(
            .Width    (NumOut),
            .CntWidth (IdxWidth)
         ) u_lzc_lo (
            .in_i    (en_lo),
            .cnt_o   (cnt_lo),
            .empty_o (empty_lo)
         );

         assign unused_empty_lo = empty_lo;
         assign tgt_idx         = empty_hi ? cnt_lo : cnt_hi;
         assign tgt_ok          = |en_i;
      end else begin : g_strict
         logic unused_en;
         assign unused_en = ^en_i;
         assign tgt_idx   = rr_q;
         assign tgt_ok    = 1'b1;
      end
   end

   // Output register and rotation pointer; a reload on handshake keeps req_o high.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         idx_q   <= '0;
         rr_q    <= '0;
      end else if (acc) begin
         valid_q <= ~tgt_drop;
         data_q  <= data_i;
         idx_q   <= tgt_idx;
         rr_q    <= rr_nxt;
      end else if (out_hs) begin
         valid_q <= 1'b0;
      end
   end

   // Decode the held index into a onehot0 valid vector.
   always_comb begin
      req_o = '0;
      for (int unsigned k = 0; k < NumOut; k++) begin
         req_o[k] = valid_q & (idx_q == idx_t'(k));
      end
   end

   assign data_o = data_q;
   assign idx_o  = idx_q;

`ifdef RR_DIST_PERF_CNT_EN
   perf_cnt_t [NumOut-1:0] perf_cnt_q;

   // Count completed downstream handshakes per port, wrapping naturally.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         perf_cnt_q <= '0;
      end else begin
         for (int unsigned k = 0; k < NumOut; k++) begin
            if (out_hs && (idx_q == idx_t'(k))) perf_cnt_q[k] <= perf_cnt_q[k] + perf_cnt_t'(1);
         end
      end
   end

   assign perf_cnt_o = perf_cnt_q;
`endif

endmodule

// File: tb/tb_rr_dist_tree.sv
// tb_rr_dist_tree: table-driven check of three rr_dist_tree configurations
// (strict rotation, fair skip, external select with NumOut=3).
module tb_rr_dist_tree;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   typedef struct {
      logic        rst;
      logic        flush;
      logic        req;
      logic [3:0]  en;
      logic [3:0]  gnt;
      logic [1:0]  sel;
      logic [31:0] data;
      logic        exp_gnt;
      logic        exp_drop;
      logic [3:0]  exp_req;
      logic [1:0]  exp_idx;
      logic [31:0] exp_data;
   } vec_t;

   typedef struct {
      logic        gnt;
      logic        drop;
      logic [3:0]  req;
      logic [1:0]  idx;
      logic [31:0] data;
   } obs_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst   [3];
   logic        flush [3];
   logic        req   [3];
   logic [3:0]  en    [3];
   logic [3:0]  gnt   [3];
   logic [1:0]  sel   [3];
   logic [31:0] din   [3];

   logic        o_gnt0, o_gnt1, o_gnt2;
   logic        o_drop0, o_drop1, o_drop2;
   logic [3:0]  o_req0, o_req1;
   logic [2:0]  o_req2;
   logic [1:0]  o_idx0, o_idx1, o_idx2;
   logic [31:0] o_data0, o_data1, o_data2;

`ifdef RR_DIST_PERF_CNT_EN
   logic [3:0][31:0] pc_rot;
   logic [3:0][31:0] pc_fair;
   logic [2:0][31:0] pc_ext;
`endif

   int unsigned checks   = 0;
   int unsigned failures = 0;

   rr_dist_tree #(.NumOut(4), .DataWidth(32), .ExtSel(1'b0), .FairDist(1'b0)) u_rot (
      .clk_i (clk), .rst_i (rst[0]), .flush_i (flush[0]), .en_i (en[0]), .sel_i (sel[0]),
      .req_i (req[0]), .gnt_o (o_gnt0), .data_i (din[0]), .req_o (o_req0), .gnt_i (gnt[0]),
      .data_o (o_data0), .idx_o (o_idx0), .drop_o (o_drop0)
`ifdef RR_DIST_PERF_CNT_EN
      , .perf_cnt_o (pc_rot)
`endif
   );

   rr_dist_tree #(.NumOut(4), .DataWidth(32), .ExtSel(1'b0), .FairDist(1'b1)) u_fair (
      .clk_i (clk), .rst_i (rst[1]), .flush_i (flush[1]), .en_i (en[1]), .sel_i (sel[1]),
      .req_i (req[1]), .gnt_o (o_gnt1), .data_i (din[1]), .req_o (o_req1), .gnt_i (gnt[1]),
      .data_o (o_data1), .idx_o (o_idx1), .drop_o (o_drop1)
`ifdef RR_DIST_PERF_CNT_EN
      , .perf_cnt_o (pc_fair)
`endif
   );

   rr_dist_tree #(.NumOut(3), .DataWidth(32), .ExtSel(1'b1), .FairDist(1'b1)) u_ext (
      .clk_i (clk), .rst_i (rst[2]), .flush_i (flush[2]), .en_i (en[2][2:0]), .sel_i (sel[2]),
      .req_i (req[2]), .gnt_o (o_gnt2), .data_i (din[2]), .req_o (o_req2), .gnt_i (gnt[2][2:0]),
      .data_o (o_data2), .idx_o (o_idx2), .drop_o (o_drop2)
`ifdef RR_DIST_PERF_CNT_EN
      , .perf_cnt_o (pc_ext)
`endif
   );

   function automatic obs_t observe(input int unsigned d);
      obs_t o;
      case (d)
         0:       o = '{o_gnt0, o_drop0, o_req0, o_idx0, o_data0};
         1:       o = '{o_gnt1, o_drop1, o_req1, o_idx1, o_data1};
         default: o = '{o_gnt2, o_drop2, {1'b0, o_req2}, o_idx2, o_data2};
      endcase
      return o;
   endfunction

   function automatic vec_t mk(input logic r, input logic f, input logic q, input logic [3:0] e,
                               input logic [3:0] g, input logic [1:0] s, input logic [31:0] dt,
                               input logic eg, input logic ed, input logic [3:0] er,
                               input logic [1:0] ei, input logic [31:0] edt);
      vec_t v;
      v = '{r, f, q, e, g, s, dt, eg, ed, er, ei, edt};
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Drive one row, check combinational outputs, then registered outputs after the edge.
   task automatic apply(input int unsigned d, input vec_t v, input string tag);
      obs_t o;
      rst[d]   = v.rst;
      flush[d] = v.flush;
      req[d]   = v.req;
      en[d]    = v.en;
      gnt[d]   = v.gnt;
      sel[d]   = v.sel;
      din[d]   = v.data;
      #1;
      o = observe(d);
      chk({tag, " gnt_o"}, 32'(o.gnt), 32'(v.exp_gnt));
      chk({tag, " drop_o"}, 32'(o.drop), 32'(v.exp_drop));
      @(posedge clk);
      #1;
      o = observe(d);
      chk({tag, " req_o"}, 32'(o.req), 32'(v.exp_req));
      chk({tag, " idx_o"}, 32'(o.idx), 32'(v.exp_idx));
      chk({tag, " data_o"}, o.data, v.exp_data);
   endtask

   vec_t rot[$];
   vec_t fair[$];
   vec_t perf[$];
   vec_t ext[$];
`ifdef RR_DIST_PERF_CNT_EN
   logic [31:0] exp_pc [4];
`endif

   initial begin
      for (int d = 0; d < 3; d++) begin
         rst[d] = H; flush[d] = L; req[d] = L; en[d] = 4'hF; gnt[d] = 4'h0; sel[d] = 2'd0; din[d] = '0;
      end

      // Strict rotation, backpressure, flush and reset mid-transfer.
      rot.push_back(mk(H, L, H, 4'hF, 4'hF, 2'd0, 32'hAA, L, L, 4'b0000, 2'd0, 32'h0));
      for (int i = 0; i < 8; i++)
         rot.push_back(mk(L, L, H, 4'hF, 4'hF, 2'd0, 32'(32'h10 + i), H, L,
                          4'(4'b0001 << (i % 4)), 2'(i % 4), 32'(32'h10 + i)));
      rot.push_back(mk(L, L, L, 4'hF, 4'hF, 2'd0, 32'h0,  H, L, 4'b0000, 2'd3, 32'h17));
      rot.push_back(mk(L, L, H, 4'hF, 4'hF, 2'd0, 32'h20, H, L, 4'b0001, 2'd0, 32'h20));
      rot.push_back(mk(L, L, H, 4'hF, 4'hF, 2'd0, 32'h21, H, L, 4'b0010, 2'd1, 32'h21));
      for (int i = 0; i < 5; i++)
         rot.push_back(mk(L, L, H, 4'hF, 4'b1101, 2'd0, 32'h30, L, L, 4'b0010, 2'd1, 32'h21));
      rot.push_back(mk(L, L, H, 4'hF, 4'hF,    2'd0, 32'h31, H, L, 4'b0100, 2'd2, 32'h31));
      rot.push_back(mk(L, H, H, 4'hF, 4'hF,    2'd0, 32'h32, L, L, 4'b0000, 2'd0, 32'h0));
      rot.push_back(mk(L, L, H, 4'hF, 4'hF,    2'd0, 32'h40, H, L, 4'b0001, 2'd0, 32'h40));
      rot.push_back(mk(L, L, H, 4'hF, 4'hF,    2'd0, 32'h41, H, L, 4'b0010, 2'd1, 32'h41));
      rot.push_back(mk(L, L, H, 4'hF, 4'hF,    2'd0, 32'h42, H, L, 4'b0100, 2'd2, 32'h42));
      rot.push_back(mk(L, H, H, 4'hF, 4'b1011, 2'd0, 32'h43, L, L, 4'b0000, 2'd0, 32'h0));
      rot.push_back(mk(L, L, H, 4'hF, 4'hF,    2'd0, 32'h44, H, L, 4'b0001, 2'd0, 32'h44));
      rot.push_back(mk(L, L, H, 4'hF, 4'hF,    2'd0, 32'h45, H, L, 4'b0010, 2'd1, 32'h45));
      rot.push_back(mk(L, L, H, 4'hF, 4'hF,    2'd0, 32'h46, H, L, 4'b0100, 2'd2, 32'h46));
      rot.push_back(mk(H, L, H, 4'hF, 4'b1011, 2'd0, 32'h47, L, L, 4'b0000, 2'd0, 32'h0));
      rot.push_back(mk(H, L, H, 4'hF, 4'hF,    2'd0, 32'h47, L, L, 4'b0000, 2'd0, 32'h0));
      rot.push_back(mk(L, L, H, 4'hF, 4'hF,    2'd0, 32'h48, H, L, 4'b0001, 2'd0, 32'h48));
      rot.push_back(mk(L, L, L, 4'hF, 4'hF,    2'd0, 32'h0,  H, L, 4'b0000, 2'd0, 32'h48));
      foreach (rot[i]) apply(0, rot[i], $sformatf("rot[%0d]", i));

      // Fair skip over disabled ports, all-disabled drain, cyclic wrap.
      fair.push_back(mk(H, L, H, 4'hF,    4'hF,    2'd0, 32'h99, L, L, 4'b0000, 2'd0, 32'h0));
      fair.push_back(mk(L, L, H, 4'b1010, 4'hF,    2'd0, 32'h50, H, L, 4'b0010, 2'd1, 32'h50));
      fair.push_back(mk(L, L, H, 4'b1010, 4'hF,    2'd0, 32'h51, H, L, 4'b1000, 2'd3, 32'h51));
      fair.push_back(mk(L, L, H, 4'b1010, 4'hF,    2'd0, 32'h52, H, L, 4'b0010, 2'd1, 32'h52));
      fair.push_back(mk(L, L, H, 4'b1010, 4'hF,    2'd0, 32'h53, H, L, 4'b1000, 2'd3, 32'h53));
      fair.push_back(mk(L, L, H, 4'b0000, 4'b0000, 2'd0, 32'h54, L, L, 4'b1000, 2'd3, 32'h53));
      fair.push_back(mk(L, L, H, 4'b0000, 4'b1000, 2'd0, 32'h54, L, L, 4'b0000, 2'd3, 32'h53));
      fair.push_back(mk(L, L, H, 4'b0100, 4'hF,    2'd0, 32'h55, H, L, 4'b0100, 2'd2, 32'h55));
      fair.push_back(mk(L, L, H, 4'b0011, 4'hF,    2'd0, 32'h56, H, L, 4'b0001, 2'd0, 32'h56));
      fair.push_back(mk(L, L, L, 4'b0011, 4'hF,    2'd0, 32'h0,  H, L, 4'b0000, 2'd0, 32'h56));
      foreach (fair[i]) apply(1, fair[i], $sformatf("fair[%0d]", i));

      // Ten handshakes on port 0, three on port 2, then flush.
      perf.push_back(mk(L, H, L, 4'hF, 4'hF, 2'd0, 32'h0, L, L, 4'b0000, 2'd0, 32'h0));
      for (int i = 0; i < 10; i++)
         perf.push_back(mk(L, L, H, 4'b0001, 4'hF, 2'd0, 32'(32'h60 + i), H, L, 4'b0001, 2'd0, 32'(32'h60 + i)));
      for (int i = 0; i < 3; i++)
         perf.push_back(mk(L, L, H, 4'b0100, 4'hF, 2'd0, 32'(32'h70 + i), H, L, 4'b0100, 2'd2, 32'(32'h70 + i)));
      perf.push_back(mk(L, L, L, 4'b0100, 4'hF, 2'd0, 32'h0, H, L, 4'b0000, 2'd2, 32'h72));
      foreach (perf[i]) apply(1, perf[i], $sformatf("perf[%0d]", i));
`ifdef RR_DIST_PERF_CNT_EN
      exp_pc = '{32'd10, 32'd0, 32'd3, 32'd0};
      for (int k = 0; k < 4; k++) chk($sformatf("perf_cnt[%0d]", k), pc_fair[k], exp_pc[k]);
`endif
      apply(1, mk(L, H, L, 4'hF, 4'hF, 2'd0, 32'h0, L, L, 4'b0000, 2'd0, 32'h0), "perf_flush");
`ifdef RR_DIST_PERF_CNT_EN
      for (int k = 0; k < 4; k++) chk($sformatf("perf_cnt_flush[%0d]", k), pc_fair[k], 32'd0);
`endif

      // External select with an out-of-range target on a 3-port instance.
      ext.push_back(mk(H, L, H, 4'hF, 4'b0111, 2'd3, 32'h77, L, L, 4'b0000, 2'd0, 32'h0));
      ext.push_back(mk(L, L, H, 4'hF, 4'b0111, 2'd2, 32'h80, H, L, 4'b0100, 2'd2, 32'h80));
      ext.push_back(mk(L, L, H, 4'hF, 4'b0111, 2'd3, 32'h81, H, H, 4'b0000, 2'd3, 32'h81));
      ext.push_back(mk(L, L, H, 4'hF, 4'b0111, 2'd0, 32'h82, H, L, 4'b0001, 2'd0, 32'h82));
      ext.push_back(mk(L, L, L, 4'hF, 4'b0111, 2'd3, 32'h0,  H, L, 4'b0000, 2'd0, 32'h82));
      ext.push_back(mk(L, L, H, 4'hF, 4'b0101, 2'd1, 32'h83, H, L, 4'b0010, 2'd1, 32'h83));
      ext.push_back(mk(L, L, H, 4'hF, 4'b0101, 2'd3, 32'h84, L, L, 4'b0010, 2'd1, 32'h83));
      ext.push_back(mk(L, L, H, 4'hF, 4'b0111, 2'd3, 32'h85, H, H, 4'b0000, 2'd3, 32'h85));
      foreach (ext[i]) apply(2, ext[i], $sformatf("ext[%0d]", i));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
